// File: rtl/rvc_asap_vga_fb_mem.sv
// Frame-buffer word array with a byte-masked core port, a hardware clear engine
// and a prefetching scan-out stream backed by a small FIFO.
module rvc_asap_vga_fb_mem #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 14,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                clock,
  input  logic                rst_n,
  input  logic                core_req,
  input  logic                core_we,
  input  logic [ADDR_W-1:0]   core_addr,
  input  logic [DATA_W/8-1:0] core_be,
  input  logic [DATA_W-1:0]   core_wdata,
  output logic [DATA_W-1:0]   core_rdata,
  output logic                core_rvalid,
  output logic                core_stall,
  input  logic                scan_start,
  input  logic [ADDR_W-1:0]   scan_base,
  input  logic [ADDR_W:0]     scan_len,
  output logic [DATA_W-1:0]   scan_data,
  output logic                scan_valid,
  input  logic                scan_ready,
  output logic                scan_done,
  output logic [15:0]         underrun_cnt,
  input  logic                fill_start,
  input  logic [DATA_W-1:0]   fill_value,
  output logic                fill_busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 2;

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   LEN_ZERO  = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W+1)'(1);
  localparam logic [PTR_W-1:0]  PTR_ZERO  = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  typedef enum logic {
    F_IDLE = 1'b0,
    F_FILL = 1'b1
  } fill_state_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } scan_state_t;

  logic [DATA_W-1:0] mem_r [DEPTH];

  fill_state_t       fill_state_r;
  fill_state_t       fill_state_nxt_s;
  logic [ADDR_W-1:0] fill_addr_r;
  logic [DATA_W-1:0] fill_val_r;
  logic              fill_busy_r;

  logic              core_wr_s;
  logic              core_rd_s;
  logic [DATA_W-1:0] core_rdata_r;
  logic              core_rvalid_r;

  logic              wr_en_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic [NB-1:0]     wr_be_s;
  logic [DATA_W-1:0] wr_data_s;

  scan_state_t       scan_state_r;
  scan_state_t       scan_state_nxt_s;
  logic [ADDR_W-1:0] scan_addr_r;
  logic [ADDR_W:0]   scan_left_r;
  logic              issue_s;
  logic              rd_pend_r;
  logic [DATA_W-1:0] rd_data_r;
  logic              scan_done_r;
  logic              scan_done_nxt_s;

  logic [DATA_W-1:0] fifo_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  fifo_cnt_r;
  logic [CNT_W-1:0]  fifo_cnt_nxt_s;
  logic              push_s;
  logic              pop_s;
  logic              scan_valid_r;
  logic [15:0]       underrun_r;

  // core_stall is the registered fill-busy flag, so it is the same signal as fill_busy
  assign core_wr_s = core_req && !fill_busy_r && core_we;
  assign core_rd_s = core_req && !fill_busy_r && !core_we;

  // Fill FSM next state
  always_comb begin
    fill_state_nxt_s = fill_state_r;
    case (fill_state_r)
      F_IDLE: begin
        if (fill_start) fill_state_nxt_s = F_FILL;
        else            fill_state_nxt_s = F_IDLE;
      end
      F_FILL: begin
        if (fill_addr_r == LAST_ADDR) fill_state_nxt_s = F_IDLE;
        else                          fill_state_nxt_s = F_FILL;
      end
      default: fill_state_nxt_s = F_IDLE;
    endcase
  end

  // Fill FSM state, sweep address and latched pattern
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      fill_state_r <= F_IDLE;
      fill_addr_r  <= ADDR_ZERO;
      fill_val_r   <= DATA_ZERO;
      fill_busy_r  <= 1'b0;
    end else begin
      fill_state_r <= fill_state_nxt_s;
      fill_busy_r  <= (fill_state_nxt_s == F_FILL);
      if (fill_state_r == F_IDLE && fill_start) begin
        fill_val_r  <= fill_value;
        fill_addr_r <= ADDR_ZERO;
      end else if (fill_state_r == F_FILL) begin
        fill_addr_r <= fill_addr_r + ADDR_ONE;
      end
    end
  end

  // Single array write port: the clear engine owns it while filling
  always_comb begin
    if (fill_state_r == F_FILL) begin
      wr_en_s   = 1'b1;
      wr_addr_s = fill_addr_r;
      wr_be_s   = {NB{1'b1}};
      wr_data_s = fill_val_r;
    end else begin
      wr_en_s   = core_wr_s;
      wr_addr_s = core_addr;
      wr_be_s   = core_be;
      wr_data_s = core_wdata;
    end
  end

  // Array contents are deliberately not reset so an aborted fill leaves old words intact
  always_ff @(posedge clock) begin
    if (wr_en_s) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be_s[b]) mem_r[wr_addr_s][b*8 +: 8] <= wr_data_s[b*8 +: 8];
      end
    end
  end

  // Core read port; data holds between reads
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      core_rdata_r  <= DATA_ZERO;
      core_rvalid_r <= 1'b0;
    end else begin
      core_rvalid_r <= core_rd_s;
      if (core_rd_s) core_rdata_r <= mem_r[core_addr];
    end
  end

  // Only issue while the FIFO can absorb every outstanding read
  assign issue_s = (scan_state_r == S_RUN) && !scan_start &&
                   ((fifo_cnt_r + {{(CNT_W-1){1'b0}}, rd_pend_r}) < CNT_FULL);

  // Scan FSM next state; a new start always pre-empts the running stream
  always_comb begin
    scan_state_nxt_s = scan_state_r;
    scan_done_nxt_s  = 1'b0;
    if (scan_start) begin
      if (scan_len == LEN_ZERO) begin
        scan_state_nxt_s = S_IDLE;
        scan_done_nxt_s  = 1'b1;
      end else begin
        scan_state_nxt_s = S_RUN;
        scan_done_nxt_s  = 1'b0;
      end
    end else begin
      case (scan_state_r)
        S_IDLE: scan_state_nxt_s = S_IDLE;
        S_RUN: begin
          if (issue_s && scan_left_r == LEN_ONE) scan_state_nxt_s = S_DRAIN;
          else                                   scan_state_nxt_s = S_RUN;
        end
        S_DRAIN: begin
          if (fifo_cnt_r == CNT_ZERO && !rd_pend_r) begin
            scan_state_nxt_s = S_IDLE;
            scan_done_nxt_s  = 1'b1;
          end else begin
            scan_state_nxt_s = S_DRAIN;
          end
        end
        default: scan_state_nxt_s = S_IDLE;
      endcase
    end
  end

  // Scan FSM state, address/length counters and the one-deep read stage
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      scan_state_r <= S_IDLE;
      scan_addr_r  <= ADDR_ZERO;
      scan_left_r  <= LEN_ZERO;
      rd_pend_r    <= 1'b0;
      rd_data_r    <= DATA_ZERO;
      scan_done_r  <= 1'b0;
    end else begin
      scan_state_r <= scan_state_nxt_s;
      scan_done_r  <= scan_done_nxt_s;
      rd_pend_r    <= issue_s;
      if (issue_s) rd_data_r <= mem_r[scan_addr_r];
      if (scan_start) begin
        scan_addr_r <= scan_base;
        scan_left_r <= scan_len;
      end else if (issue_s) begin
        scan_addr_r <= scan_addr_r + ADDR_ONE;
        scan_left_r <= scan_left_r - LEN_ONE;
      end
    end
  end

  assign push_s = rd_pend_r && !scan_start;
  assign pop_s  = scan_valid_r && scan_ready && !scan_start;

  // FIFO occupancy update
  always_comb begin
    fifo_cnt_nxt_s = fifo_cnt_r;
    if (scan_start)            fifo_cnt_nxt_s = CNT_ZERO;
    else if (push_s && !pop_s) fifo_cnt_nxt_s = fifo_cnt_r + CNT_ONE;
    else if (!push_s && pop_s) fifo_cnt_nxt_s = fifo_cnt_r - CNT_ONE;
    else                       fifo_cnt_nxt_s = fifo_cnt_r;
  end

  // Prefetch FIFO storage and pointers; scan_start flushes it
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_r[i] <= DATA_ZERO;
      wr_ptr_r     <= PTR_ZERO;
      rd_ptr_r     <= PTR_ZERO;
      fifo_cnt_r   <= CNT_ZERO;
      scan_valid_r <= 1'b0;
    end else begin
      fifo_cnt_r   <= fifo_cnt_nxt_s;
      scan_valid_r <= (fifo_cnt_nxt_s != CNT_ZERO);
      if (scan_start) begin
        wr_ptr_r <= PTR_ZERO;
        rd_ptr_r <= PTR_ZERO;
      end else begin
        if (push_s) begin
          fifo_r[wr_ptr_r] <= rd_data_r;
          wr_ptr_r         <= wr_ptr_r + PTR_ONE;
        end
        if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Starved-consumer counter, saturating
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      underrun_r <= 16'h0000;
    end else if (scan_state_r == S_RUN && scan_ready && !scan_valid_r &&
                 underrun_r != 16'hFFFF) begin
      underrun_r <= underrun_r + 16'h0001;
    end
  end

  assign core_rdata   = core_rdata_r;
  assign core_rvalid  = core_rvalid_r;
  assign core_stall   = fill_busy_r;
  assign fill_busy    = fill_busy_r;
  assign scan_data    = fifo_r[rd_ptr_r];
  assign scan_valid   = scan_valid_r;
  assign scan_done    = scan_done_r;
  assign underrun_cnt = underrun_r;

endmodule

// File: tb/tb_rvc_asap_vga_fb_mem.sv
// Directed self-checking bench for rvc_asap_vga_fb_mem.
module tb_rvc_asap_vga_fb_mem;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        core_req, core_we;
  logic [13:0] core_addr;
  logic [3:0]  core_be;
  logic [31:0] core_wdata, core_rdata;
  logic        core_rvalid, core_stall;
  logic        scan_start;
  logic [13:0] scan_base;
  logic [14:0] scan_len;
  logic [31:0] scan_data;
  logic        scan_valid, scan_ready, scan_done;
  logic [15:0] underrun_cnt;
  logic        fill_start;
  logic [31:0] fill_value;
  logic        fill_busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  rvc_asap_vga_fb_mem #(.DATA_W(32), .ADDR_W(14), .FIFO_DEPTH(8)) dut (
    .clock(clock), .rst_n(rst_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_be(core_be),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_rvalid(core_rvalid),
    .core_stall(core_stall),
    .scan_start(scan_start), .scan_base(scan_base), .scan_len(scan_len),
    .scan_data(scan_data), .scan_valid(scan_valid), .scan_ready(scan_ready),
    .scan_done(scan_done), .underrun_cnt(underrun_cnt),
    .fill_start(fill_start), .fill_value(fill_value), .fill_busy(fill_busy)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic core_write(input logic [13:0] a, input logic [31:0] d, input logic [3:0] be);
    core_req = 1'b1; core_we = 1'b1; core_addr = a; core_wdata = d; core_be = be;
    tick();
    core_req = 1'b0; core_we = 1'b0;
  endtask

  task automatic core_read(input logic [13:0] a, output logic [31:0] d, output logic v);
    core_req = 1'b1; core_we = 1'b0; core_addr = a;
    tick();
    core_req = 1'b0;
    d = core_rdata;
    v = core_rvalid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    core_req = 1'b0; core_we = 1'b0; core_addr = 14'h0; core_be = 4'h0; core_wdata = 32'h0;
    scan_start = 1'b0; scan_base = 14'h0; scan_len = 15'h0; scan_ready = 1'b0;
    fill_start = 1'b0; fill_value = 32'h0;
    tick();
    tick();
    n_cmp++; if (core_rdata !== 32'h0) begin n_err++; $display("FAIL reset_core_rdata got %h want 0", core_rdata); end
    n_cmp++; if (core_rvalid !== 1'b0) begin n_err++; $display("FAIL reset_core_rvalid got %b want 0", core_rvalid); end
    n_cmp++; if (core_stall !== 1'b0) begin n_err++; $display("FAIL reset_core_stall got %b want 0", core_stall); end
    n_cmp++; if (scan_data !== 32'h0) begin n_err++; $display("FAIL reset_scan_data got %h want 0", scan_data); end
    n_cmp++; if (scan_valid !== 1'b0) begin n_err++; $display("FAIL reset_scan_valid got %b want 0", scan_valid); end
    n_cmp++; if (scan_done !== 1'b0) begin n_err++; $display("FAIL reset_scan_done got %b want 0", scan_done); end
    n_cmp++; if (underrun_cnt !== 16'h0) begin n_err++; $display("FAIL reset_underrun got %h want 0", underrun_cnt); end
    n_cmp++; if (fill_busy !== 1'b0) begin n_err++; $display("FAIL reset_fill_busy got %b want 0", fill_busy); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_byte_write();
    logic [31:0] d;
    logic v;
    core_write(14'd5, 32'hAABBCCDD, 4'hF);
    core_write(14'd5, 32'h11223344, 4'h5);
    core_read(14'd5, d, v);
    n_cmp++; if (v !== 1'b1) begin n_err++; $display("FAIL bw_rvalid got %b want 1", v); end
    n_cmp++; if (d !== 32'hAA22CC44) begin n_err++; $display("FAIL bw_rdata got %h want AA22CC44", d); end
    tick();
    n_cmp++; if (core_rvalid !== 1'b0) begin n_err++; $display("FAIL bw_rvalid_drop got %b want 0", core_rvalid); end
    n_cmp++; if (core_rdata !== 32'hAA22CC44) begin n_err++; $display("FAIL bw_rdata_hold got %h want AA22CC44", core_rdata); end
  endtask

  task automatic test_fill();
    logic [31:0] d;
    logic v;
    int cnt;
    core_write(14'h3FFF, 32'hFFFFFFFF, 4'hF);
    core_write(14'd7, 32'h00000077, 4'hF);
    fill_value = 32'h0;
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    cnt = 0;
    while (fill_busy === 1'b1 && cnt < 20000) begin
      if (cnt == 50) begin
        n_cmp++; if (core_stall !== 1'b1) begin n_err++; $display("FAIL fill_stall got %b want 1", core_stall); end
      end
      if (cnt == 100) begin
        core_req = 1'b1; core_we = 1'b1; core_addr = 14'd7; core_wdata = 32'hCAFEF00D; core_be = 4'hF;
        fill_start = 1'b1; fill_value = 32'h55555555;
      end else begin
        core_req = 1'b0; core_we = 1'b0; fill_start = 1'b0;
      end
      cnt++;
      tick();
    end
    n_cmp++; if (cnt != 16384) begin n_err++; $display("FAIL fill_busy_cycles got %0d want 16384", cnt); end
    n_cmp++; if (core_stall !== 1'b0) begin n_err++; $display("FAIL fill_stall_end got %b want 0", core_stall); end
    core_read(14'h3FFF, d, v);
    n_cmp++; if (d !== 32'h0 || v !== 1'b1) begin n_err++; $display("FAIL fill_last_word got %h/%b want 0/1", d, v); end
    core_read(14'd7, d, v);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL fill_core_write_ignored got %h want 0", d); end
    core_read(14'd5, d, v);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL fill_word5 got %h want 0", d); end
  endtask

  task automatic test_fill_reset();
    logic [31:0] d;
    logic v;
    core_write(14'h3000, 32'hABCD0123, 4'hF);
    core_write(14'd20, 32'h00002020, 4'hF);
    fill_value = 32'h00000001;
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (fill_busy !== 1'b0 || core_stall !== 1'b0) begin n_err++; $display("FAIL fillrst_busy got %b/%b want 0/0", fill_busy, core_stall); end
    tick();
    rst_n = 1'b1;
    tick();
    core_read(14'd3, d, v);
    n_cmp++; if (d !== 32'h1) begin n_err++; $display("FAIL fillrst_written got %h want 1", d); end
    core_read(14'd20, d, v);
    n_cmp++; if (d !== 32'h00002020) begin n_err++; $display("FAIL fillrst_unreached got %h want 2020", d); end
    core_read(14'h3000, d, v);
    n_cmp++; if (d !== 32'hABCD0123) begin n_err++; $display("FAIL fillrst_far got %h want ABCD0123", d); end
  endtask

  task automatic test_read_first();
    logic [31:0] d;
    logic v;
    int guard;
    do_reset();
    core_write(14'h100, 32'h12345678, 4'hF);
    scan_base = 14'h100; scan_len = 15'd1; scan_ready = 1'b0; scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    core_req = 1'b1; core_we = 1'b1; core_addr = 14'h100; core_wdata = 32'hDEADBEEF; core_be = 4'hF;
    tick();
    core_req = 1'b0; core_we = 1'b0;
    guard = 0;
    while (scan_valid !== 1'b1 && guard < 20) begin tick(); guard++; end
    n_cmp++; if (scan_valid !== 1'b1) begin n_err++; $display("FAIL rf_valid_timeout got %b want 1", scan_valid); end
    n_cmp++; if (scan_data !== 32'h12345678) begin n_err++; $display("FAIL rf_old_data got %h want 12345678", scan_data); end
    scan_ready = 1'b1;
    guard = 0;
    while (scan_done !== 1'b1 && guard < 20) begin tick(); guard++; end
    n_cmp++; if (scan_done !== 1'b1) begin n_err++; $display("FAIL rf_done_timeout got %b want 1", scan_done); end
    scan_ready = 1'b0;
    core_read(14'h100, d, v);
    n_cmp++; if (d !== 32'hDEADBEEF) begin n_err++; $display("FAIL rf_new_data got %h want DEADBEEF", d); end
  endtask

  task automatic test_scan_wrap();
    logic [31:0] got [8];
    logic [31:0] exp_w [4];
    int n, dones, n_at_done;
    do_reset();
    exp_w[0] = 32'hA0000001; exp_w[1] = 32'hA0000002; exp_w[2] = 32'hA0000003; exp_w[3] = 32'hA0000004;
    core_write(14'h3FFE, exp_w[0], 4'hF);
    core_write(14'h3FFF, exp_w[1], 4'hF);
    core_write(14'h0000, exp_w[2], 4'hF);
    core_write(14'h0001, exp_w[3], 4'hF);
    scan_ready = 1'b1; scan_base = 14'h3FFE; scan_len = 15'd4; scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    n = 0; dones = 0; n_at_done = -1;
    for (int c = 0; c < 40; c++) begin
      if (scan_valid === 1'b1 && scan_ready === 1'b1) begin
        if (n < 8) got[n] = scan_data;
        n++;
      end
      if (scan_done === 1'b1) begin dones++; n_at_done = n; end
      tick();
    end
    scan_ready = 1'b0;
    n_cmp++; if (n != 4) begin n_err++; $display("FAIL wrap_count got %0d want 4", n); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (got[i] !== exp_w[i]) begin n_err++; $display("FAIL wrap_word%0d got %h want %h", i, got[i], exp_w[i]); end
    end
    n_cmp++; if (dones != 1) begin n_err++; $display("FAIL wrap_done_pulses got %0d want 1", dones); end
    n_cmp++; if (n_at_done != 4) begin n_err++; $display("FAIL wrap_done_order got %0d want 4", n_at_done); end
    n_cmp++; if ((underrun_cnt != 16'h0) !== 1'b1) begin n_err++; $display("FAIL wrap_underrun got %h want nonzero", underrun_cnt); end
  endtask

  task automatic test_len_zero();
    scan_base = 14'h123; scan_len = 15'd0; scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    n_cmp++; if (scan_done !== 1'b1) begin n_err++; $display("FAIL len0_done got %b want 1", scan_done); end
    n_cmp++; if (scan_valid !== 1'b0) begin n_err++; $display("FAIL len0_valid got %b want 0", scan_valid); end
    tick();
    n_cmp++; if (scan_done !== 1'b0 || scan_valid !== 1'b0) begin n_err++; $display("FAIL len0_after got %b/%b want 0/0", scan_done, scan_valid); end
  endtask

  task automatic test_backpressure();
    int maxocc, n, dones;
    do_reset();
    for (int i = 0; i < 64; i++) core_write(14'h200 + 14'(i), 32'hB0000000 + 32'(i), 4'hF);
    scan_ready = 1'b0; scan_base = 14'h200; scan_len = 15'd64; scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    maxocc = 0;
    repeat (100) begin
      if (int'(dut.fifo_cnt_r) > maxocc) maxocc = int'(dut.fifo_cnt_r);
      tick();
    end
    n_cmp++; if (maxocc != 8) begin n_err++; $display("FAIL bp_occupancy got %0d want 8", maxocc); end
    n_cmp++; if (underrun_cnt !== 16'h0) begin n_err++; $display("FAIL bp_underrun_hold got %h want 0", underrun_cnt); end
    scan_ready = 1'b1;
    n = 0; dones = 0;
    for (int c = 0; c < 300; c++) begin
      if (int'(dut.fifo_cnt_r) > maxocc) maxocc = int'(dut.fifo_cnt_r);
      if (scan_valid === 1'b1) begin
        n_cmp++;
        if (scan_data !== 32'hB0000000 + 32'(n)) begin
          n_err++; $display("FAIL bp_word%0d got %h want %h", n, scan_data, 32'hB0000000 + 32'(n));
        end
        n++;
      end
      if (scan_done === 1'b1) dones++;
      tick();
    end
    scan_ready = 1'b0;
    n_cmp++; if (n != 64) begin n_err++; $display("FAIL bp_count got %0d want 64", n); end
    n_cmp++; if (dones != 1) begin n_err++; $display("FAIL bp_done_pulses got %0d want 1", dones); end
    n_cmp++; if (maxocc > 8) begin n_err++; $display("FAIL bp_overflow got %0d want <=8", maxocc); end
    n_cmp++; if (underrun_cnt !== 16'h0) begin n_err++; $display("FAIL bp_underrun_end got %h want 0", underrun_cnt); end
  endtask

  task automatic test_restart();
    int guard, n, dones;
    do_reset();
    for (int i = 0; i < 20; i++) core_write(14'h300 + 14'(i), 32'hC0000000 + 32'(i), 4'hF);
    for (int i = 0; i < 4; i++) core_write(14'h400 + 14'(i), 32'hD0000000 + 32'(i), 4'hF);
    scan_ready = 1'b0; scan_base = 14'h300; scan_len = 15'd20; scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    guard = 0;
    while (int'(dut.fifo_cnt_r) != 3 && guard < 20) begin tick(); guard++; end
    n_cmp++; if (int'(dut.fifo_cnt_r) != 3) begin n_err++; $display("FAIL rs_queue3 got %0d want 3", int'(dut.fifo_cnt_r)); end
    scan_base = 14'h400; scan_len = 15'd4; scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    n_cmp++; if (scan_valid !== 1'b0) begin n_err++; $display("FAIL rs_flush got %b want 0", scan_valid); end
    scan_ready = 1'b1;
    n = 0; dones = 0;
    for (int c = 0; c < 60; c++) begin
      if (scan_valid === 1'b1) begin
        n_cmp++;
        if (scan_data !== 32'hD0000000 + 32'(n)) begin
          n_err++; $display("FAIL rs_word%0d got %h want %h", n, scan_data, 32'hD0000000 + 32'(n));
        end
        n++;
      end
      if (scan_done === 1'b1) dones++;
      tick();
    end
    scan_ready = 1'b0;
    n_cmp++; if (n != 4) begin n_err++; $display("FAIL rs_count got %0d want 4", n); end
    n_cmp++; if (dones != 1) begin n_err++; $display("FAIL rs_done_pulses got %0d want 1", dones); end
  endtask

  task automatic test_scan_reset();
    int bad;
    scan_ready = 1'b1; scan_base = 14'h200; scan_len = 15'd64; scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (scan_valid !== 1'b0 || scan_done !== 1'b0 || underrun_cnt !== 16'h0) begin
      n_err++; $display("FAIL srst_outputs got %b/%b/%h want 0/0/0", scan_valid, scan_done, underrun_cnt);
    end
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (scan_done === 1'b1 || scan_valid === 1'b1) bad++;
      tick();
    end
    scan_ready = 1'b0;
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL srst_no_activity got %0d want 0", bad); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_byte_write();
    test_fill();
    test_fill_reset();
    test_read_first();
    test_scan_wrap();
    test_len_zero();
    test_backpressure();
    test_restart();
    test_scan_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
